gcd_seq: RTL and testbench

- Sequential GCD engine: computes gcd(a, b) of two unsigned WIDTH-bit operands by repeated subtraction (Euclid's subtraction form).
- Uses a single subtractor datapath (in1 - in2) shared between the two operand registers, one subtraction per clock.
- Sits between a requester (start/done handshake) and the GCD datapath.
- Reports the result and the number of subtraction steps taken.

---
 rtl/gcd_pkg.sv | 9 +
 rtl/gcd_dp.sv | 42 ++++
 rtl/gcd_seq.sv | 71 +++++++
 tb/tb_gcd_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default width for the gcd engine
package gcd_pkg;
    localparam int DEF_WIDTH = 16;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gcd_dp.sv
// gcd_dp: operand registers, unsigned comparator flags and one shared subtractor
module gcd_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sub_a,
    input  logic             sub_b,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_zero,
    output logic             b_zero
);
    logic [WIDTH-1:0] in1, in2, diff;
    assign a_gt_b = reg_a > reg_b;
    assign a_eq_b = reg_a == reg_b;
    assign a_zero = reg_a == '0;
    assign b_zero = reg_b == '0;
    // larger minus smaller, so the difference never wraps
    assign in1  = a_gt_b ? reg_a : reg_b;
    assign in2  = a_gt_b ? reg_b : reg_a;
    assign diff = in1 - in2;
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
        end else if (load) begin
            reg_a <= a_in;
            reg_b <= b_in;
        end else begin
            if (sub_a) reg_a <= diff;
            if (sub_b) reg_b <= diff;
        end
    end
endmodule

// File: rtl/gcd_seq.sv
// gcd_seq: sequential subtraction-form gcd with start/done handshake and step count
module gcd_seq
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iter_count
);
    state_t state;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic a_gt_b, a_eq_b, a_zero, b_zero, load, sub_a, sub_b, stepping;
    assign load     = state == ST_IDLE && start;
    assign stepping = state == ST_CALC && !a_zero && !b_zero && !a_eq_b;
    assign sub_a    = stepping && a_gt_b;
    assign sub_b    = stepping && !a_gt_b;
    gcd_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .sub_a  (sub_a),
        .sub_b  (sub_b),
        .a_in   (a_in),
        .b_in   (b_in),
        .reg_a  (reg_a),
        .reg_b  (reg_b),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_zero (a_zero),
        .b_zero (b_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            iter_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state      <= ST_CALC;
                    busy       <= 1'b1;
                    iter_count <= '0;
                end
                ST_CALC: if (a_zero || b_zero || a_eq_b) begin
                    // with a zero operand the OR picks the other one; when equal it is either
                    result <= a_zero || b_zero ? reg_a | reg_b : reg_a;
                    state  <= ST_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    iter_count <= iter_count + 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_seq.sv
// tb_gcd_seq: randomized scoreboard bench for gcd_seq against a division-based Euclid model
module tb_gcd_seq;
    localparam int W = 16;
    typedef struct {
        int a;
        int b;
        int g;
        int n;
        int due;
    } exp_t;
    logic clk = 0, rst = 1, start = 0;
    logic [W-1:0] a_in = 0, b_in = 0;
    logic busy, done;
    logic [W-1:0] result, iter_count;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, exp_hold = 0;
    logic rst_q = 1, mon_en = 0;

    gcd_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // gcd by remainders; subtraction count is the sum of quotients less the final equal step
    function automatic void ref_gcd(input int a, input int b, output int g, output int n);
        int x, y, r, s;
        if (a == 0 || b == 0) begin
            g = a | b;
            n = 0;
        end else begin
            x = a;
            y = b;
            s = 0;
            while (y != 0) begin
                s += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            n = s - 1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        exp_t e;
        if (rst_q) begin
            exp_hold = 0;
            busy_cnt = 0;
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_iter", int'(iter_count), 0);
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", int'(result), e.g);
                    chk("iter_count", int'(iter_count), e.n);
                    chk("done_cycle", cyc, e.due);
                    chk("busy_cycles", busy_cnt, e.n + 1);
                    exp_hold = e.g;
                end
                busy_cnt = 0;
            end
        end
        chk("result_hold", int'(result), exp_hold);
    end

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 70000) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic issue(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        ref_gcd(a, b, e.g, e.n);
        @(posedge clk);
        #1;
        start = 1;
        a_in = W'(a);
        b_in = W'(b);
        e.due = cyc + e.n + 2;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic req(input int a, input int b);
        issue(a, b);
        wait_done();
    endtask

    initial begin
        int a, b;
        repeat (3) @(posedge clk);
        mon_en = 1;
        #1;
        rst = 0;
        req(12, 8);
        req(9, 9);
        req(0, 7);
        req(7, 0);
        req(0, 0);
        req(48, 180);
        req(65535, 1);
        issue(12, 8);
        start = 1;
        a_in = 100;
        b_in = 10;
        @(posedge clk);
        #1;
        start = 0;
        wait_done();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        req(100, 10);
        @(posedge clk);
        #1;
        start = 1;
        a_in = 16'hffff;
        b_in = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (20) @(posedge clk);
        req(12, 8);
        req(21, 6);
        req(17, 5);
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 400));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 400));
            req(a, b);
        end
        repeat (5) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
